// File: rtl/sa_pkg.sv
// Shared systolic-array types: element/row types, array defaults and the collector read-FSM states.
package sa_pkg;

    localparam int SA_WIDTH = 16;
    localparam int SA_SIZE  = 4;

    typedef logic [SA_WIDTH-1:0]               elem_t;
    typedef logic [SA_SIZE-1:0][SA_WIDTH-1:0]  row_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage : sa_pkg

// File: rtl/sa_col_wptr.sv
// Per-column write pointer for the collector: tracks (bank,row), rejects writes into occupied slots.
module sa_col_wptr
    import sa_pkg::*;
#(
    parameter  int SIZE = SA_SIZE,
    localparam int RW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_vld,
    input  logic [SIZE-1:0] i_full_b0,
    input  logic [SIZE-1:0] i_full_b1,
    output logic            o_we,
    output logic            o_drop,
    output logic [RW-1:0]   o_wr_row,
    output logic            o_wr_bank
);

    localparam logic [RW-1:0] LAST_ROW = RW'(SIZE - 1);

    logic [RW-1:0] row_q, row_d;
    logic          bank_q, bank_d;
    logic          tgt_full_s;

    // Occupancy check of the target slot and pointer advance on an accepted write.
    always_comb begin
        tgt_full_s = bank_q ? i_full_b1[row_q] : i_full_b0[row_q];
        o_we       = i_vld & ~tgt_full_s;
        o_drop     = i_vld & tgt_full_s;
        row_d      = row_q;
        bank_d     = bank_q;
        if (o_we) begin
            if (row_q == LAST_ROW) begin
                row_d  = {RW{1'b0}};
                bank_d = ~bank_q;
            end else begin
                row_d  = row_q + RW'(1);
                bank_d = bank_q;
            end
        end else begin
            row_d  = row_q;
            bank_d = bank_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= {RW{1'b0}};
            bank_q <= 1'b0;
        end else if (i_clr) begin
            row_q  <= {RW{1'b0}};
            bank_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            bank_q <= bank_d;
        end
    end

    assign o_wr_row  = row_q;
    assign o_wr_bank = bank_q;

endmodule : sa_col_wptr

// File: rtl/sa_collector.sv
// De-skews per-column systolic C outputs into whole rows (2-bank buffer) and streams them out.
// Optional build macro SA_COLLECT_RELU_EN applies ReLU on the output path only.
module sa_collector
    import sa_pkg::*;
#(
    parameter  int WIDTH = SA_WIDTH,
    parameter  int SIZE  = SA_SIZE,
    localparam int RW    = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clr,
    input  logic [SIZE-1:0]       i_c_vld,
    input  logic [SIZE*WIDTH-1:0] i_c_rows,
    output logic                  o_row_vld,
    input  logic                  i_row_rdy,
    output logic [SIZE*WIDTH-1:0] o_row,
    output logic [RW-1:0]         o_row_idx,
    output logic                  o_last,
    output logic                  o_ovf
);

    localparam logic [RW-1:0] LAST_ROW = RW'(SIZE - 1);

    logic [WIDTH-1:0]                 mem_q [2][SIZE][SIZE];
    logic [1:0][SIZE-1:0][SIZE-1:0]   full_q, full_d;

    logic [SIZE-1:0] we_s;
    logic [SIZE-1:0] drop_s;
    logic [RW-1:0]   wr_row_s [SIZE];
    logic [SIZE-1:0] wr_bank_s;

    state_t                state_q, state_d;
    logic [RW-1:0]         rd_row_q, rd_row_d;
    logic                  rd_bank_q, rd_bank_d;
    logic                  hs_s, load_s;
    logic [RW-1:0]         ld_row_s;
    logic                  ld_bank_s;
    logic [RW-1:0]         nxt_row_s;
    logic                  nxt_bank_s;
    logic                  cur_cmp_s, nxt_cmp_s;

    logic [SIZE*WIDTH-1:0] row_q, row_d;
    logic [RW-1:0]         idx_q, idx_d;
    logic                  last_q, last_d;
    logic                  ovf_q, ovf_d;
    logic [WIDTH-1:0]      elem_s;

    for (genvar j = 0; j < SIZE; j++) begin : g_col
        logic [SIZE-1:0] full_b0_s;
        logic [SIZE-1:0] full_b1_s;

        for (genvar r = 0; r < SIZE; r++) begin : g_row
            assign full_b0_s[r] = full_q[0][r][j];
            assign full_b1_s[r] = full_q[1][r][j];
        end

        sa_col_wptr #(.SIZE(SIZE)) u_wptr (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_clr     (i_clr),
            .i_vld     (i_c_vld[j]),
            .i_full_b0 (full_b0_s),
            .i_full_b1 (full_b1_s),
            .o_we      (we_s[j]),
            .o_drop    (drop_s[j]),
            .o_wr_row  (wr_row_s[j]),
            .o_wr_bank (wr_bank_s[j])
        );
    end

    // Element storage; validity is tracked by full_q, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        for (int j = 0; j < SIZE; j++) begin
            if (we_s[j]) begin
                mem_q[wr_bank_s[j]][wr_row_s[j]][j] <= i_c_rows[j*WIDTH +: WIDTH];
            end
        end
    end

    // Occupancy update: accepted writes set bits, a read handshake clears its whole row.
    always_comb begin
        full_d = full_q;
        for (int j = 0; j < SIZE; j++) begin
            full_d[wr_bank_s[j]][wr_row_s[j]][j] = full_d[wr_bank_s[j]][wr_row_s[j]][j] | we_s[j];
        end
        full_d[rd_bank_q][rd_row_q] = hs_s ? {SIZE{1'b0}} : full_d[rd_bank_q][rd_row_q];
    end

    assign nxt_row_s  = (rd_row_q == LAST_ROW) ? {RW{1'b0}} : rd_row_q + RW'(1);
    assign nxt_bank_s = (rd_row_q == LAST_ROW) ? ~rd_bank_q : rd_bank_q;
    assign cur_cmp_s  = &full_q[rd_bank_q][rd_row_q];
    assign nxt_cmp_s  = &full_q[nxt_bank_s][nxt_row_s];

    // Read FSM: present a row once complete, advance on handshake, chain if the next is ready.
    always_comb begin
        state_d   = state_q;
        rd_row_d  = rd_row_q;
        rd_bank_d = rd_bank_q;
        hs_s      = 1'b0;
        load_s    = 1'b0;
        ld_row_s  = rd_row_q;
        ld_bank_s = rd_bank_q;
        case (state_q)
            IDLE: begin
                if (cur_cmp_s) begin
                    state_d = PRESENT;
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                hs_s = i_row_rdy;
                if (i_row_rdy) begin
                    rd_row_d  = nxt_row_s;
                    rd_bank_d = nxt_bank_s;
                    ld_row_s  = nxt_row_s;
                    ld_bank_s = nxt_bank_s;
                    if (nxt_cmp_s) begin
                        state_d = PRESENT;
                        load_s  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = PRESENT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output row register: loaded when a row becomes presented, zeroed when nothing is.
    always_comb begin
        row_d  = row_q;
        idx_d  = idx_q;
        last_d = last_q;
        elem_s = {WIDTH{1'b0}};
        if (load_s) begin
            for (int j = 0; j < SIZE; j++) begin
                elem_s = mem_q[ld_bank_s][ld_row_s][j];
`ifdef SA_COLLECT_RELU_EN
                row_d[j*WIDTH +: WIDTH] = elem_s[WIDTH-1] ? {WIDTH{1'b0}} : elem_s;
`else
                row_d[j*WIDTH +: WIDTH] = elem_s;
`endif
            end
            idx_d  = ld_row_s;
            last_d = (ld_row_s == LAST_ROW);
        end else if (hs_s) begin
            row_d  = {(SIZE*WIDTH){1'b0}};
            idx_d  = {RW{1'b0}};
            last_d = 1'b0;
        end else begin
            row_d  = row_q;
            idx_d  = idx_q;
            last_d = last_q;
        end
        ovf_d = ovf_q | (|drop_s);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= '0;
            state_q   <= IDLE;
            rd_row_q  <= {RW{1'b0}};
            rd_bank_q <= 1'b0;
            row_q     <= {(SIZE*WIDTH){1'b0}};
            idx_q     <= {RW{1'b0}};
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (i_clr) begin
            full_q    <= '0;
            state_q   <= IDLE;
            rd_row_q  <= {RW{1'b0}};
            rd_bank_q <= 1'b0;
            row_q     <= {(SIZE*WIDTH){1'b0}};
            idx_q     <= {RW{1'b0}};
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            state_q   <= state_d;
            rd_row_q  <= rd_row_d;
            rd_bank_q <= rd_bank_d;
            row_q     <= row_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

    assign o_row_vld = (state_q == PRESENT);
    assign o_row     = row_q;
    assign o_row_idx = idx_q;
    assign o_last    = last_q;
    assign o_ovf     = ovf_q;

endmodule : sa_collector
